// File: rtl/sum_disp_pkg.sv
// Shared types and constants for the BCD sum display: FSM states,
// active-low 7-segment patterns {g,f,e,d,c,b,a} and digit-enable codes.
package sum_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; codes 10..15 blank.
module seg7_decode
  import sum_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Accepts a binary sum over valid/ready, converts it to two BCD digits with a
// one-shift-per-clock double-dabble engine, and multiplexes them onto a 2-digit display.
module sum_bcd_display
  import sum_disp_pkg::*;
#(
  parameter int SUM_W       = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic             conv_done,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic [6:0]       seg,
  output logic [1:0]       an
);

  localparam int ITER_W = $clog2(SUM_W + 1);
  localparam int CNT_W  = $clog2(REFRESH_DIV);

  state_t              state, state_nxt;
  logic [ITER_W-1:0]   iter;
  logic [SUM_W-1:0]    shreg;
  logic [7:0]          bcd;
  logic [7:0]          bcd_adj;
  logic [CNT_W-1:0]    cnt;
  logic                digit_sel;
  logic [3:0]          disp_digit;
  logic [6:0]          dec_seg;

  // Per-nibble +3 adjust; nibbles never carry into each other.
  function automatic logic [7:0] dabble_adj(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

  assign bcd_adj   = dabble_adj(bcd);
  assign sum_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sum_valid) state_nxt = SHIFT;
      SHIFT:   if (iter == ITER_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      iter      <= '0;
      conv_done <= 1'b0;
      tens      <= 4'd0;
      ones      <= 4'd0;
    end else begin
      state     <= state_nxt;
      conv_done <= (state == DONE);
      case (state)
        IDLE:  if (sum_valid) iter <= ITER_W'(SUM_W);
        SHIFT: iter <= iter - ITER_W'(1);
        DONE: begin
          tens <= bcd[7:4];
          ones <= bcd[3:0];
        end
        default: ;
      endcase
    end
  end

  // Scratch datapath: only meaningful between accept and DONE, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && sum_valid) begin
      shreg <= sum;
      bcd   <= 8'd0;
    end else if (state == SHIFT) begin
      bcd   <= {bcd_adj[6:0], shreg[SUM_W-1]};
      shreg <= shreg << 1;
    end
  end

  // Display refresh: digit_sel toggles once per REFRESH_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_sel <= 1'b0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt       <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign disp_digit = digit_sel ? tens : ones;

  seg7_decode u_dec (
    .digit (disp_digit),
    .seg   (dec_seg)
  );

  // Leading zero on the tens digit is blanked; ones always shows.
  assign seg = (digit_sel && tens == 4'd0) ? SEG_BLANK : dec_seg;
  assign an  = digit_sel ? AN_TENS : AN_ONES;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Randomized self-checking bench for sum_bcd_display against an arithmetic
// reference (v/10, v%10, segment table, refresh phase from a cycle count).
module tb_sum_bcd_display;

  localparam int SUM_W = 5;
  localparam int RDIV  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sum = '0;
  logic       sum_valid = 1'b0;
  logic       sum_ready, conv_done;
  logic [3:0] tens, ones;
  logic [6:0] seg;
  logic [1:0] an;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_t    = 0;
  int exp_o    = 0;

  sum_bcd_display #(.SUM_W(SUM_W), .REFRESH_DIV(RDIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .conv_done (conv_done),
    .tens      (tens),
    .ones      (ones),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; drives the expected refresh phase.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_disp(string tag);
    logic [1:0] ea;
    logic [6:0] es;
    if (((cyc / RDIV) % 2) == 1) begin
      ea = 2'b01;
      es = (exp_t == 0) ? 7'b1111111 : seg_of(exp_t);
    end else begin
      ea = 2'b10;
      es = seg_of(exp_o);
    end
    check({tag, "_an"}, 32'(an), 32'(ea));
    check({tag, "_seg"}, 32'(seg), 32'(es));
  endtask

  task automatic wait_done(output int low, output bit got);
    low = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (conv_done) got = 1'b1;
      else if (!sum_ready) low++;
    end
    if (!got) check("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic convert(int v, string tag);
    int low;
    int low2;
    bit got;
    sum = v[4:0];
    sum_valid = 1'b1;
    check({tag, "_rdy_pre"}, 32'(sum_ready), 32'd1);
    @(negedge clk);
    sum_valid = 1'b0;
    low = sum_ready ? 0 : 1;
    wait_done(low2, got);
    if (got) begin
      exp_t = v / 10;
      exp_o = v % 10;
      check({tag, "_busy"}, 32'(low + low2), 32'(SUM_W + 1));
      check({tag, "_tens"}, 32'(tens), 32'(exp_t));
      check({tag, "_ones"}, 32'(ones), 32'(exp_o));
      check({tag, "_rdy"}, 32'(sum_ready), 32'd1);
      check_disp(tag);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(conv_done), 32'd0);
    end
  endtask

  task automatic seg_phase(logic [1:0] an_want, logic [6:0] seg_want, string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * RDIV && !seen; i++) begin
      if (an == an_want) begin
        seen = 1'b1;
        check(tag, 32'(seg), 32'(seg_want));
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) check({tag, "_phase"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int low;
    int pulses;
    bit g1, g2;
    int v;

    // Reset held two clocks
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(sum_ready), 32'd1);
    check("rst_tens", 32'(tens), 32'd0);
    check("rst_ones", 32'(ones), 32'd0);
    check("rst_an", 32'(an), 32'(2'b10));
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    check("rst_done", 32'(conv_done), 32'd0);
    rst = 1'b0;

    // Refresh phase alternation
    for (int i = 0; i < 4 * RDIV; i++) begin
      @(negedge clk);
      check_disp("refresh");
    end

    // 31 -> tens 3, ones 1
    convert(31, "s31");
    seg_phase(2'b10, 7'b1111001, "s31_ones_seg");
    seg_phase(2'b01, 7'b0110000, "s31_tens_seg");

    // 0 -> leading-zero blank
    convert(0, "s0");
    seg_phase(2'b01, 7'b1111111, "s0_tens_blank");
    seg_phase(2'b10, 7'b1000000, "s0_ones_seg");

    // valid held; data changes while busy
    @(negedge clk);
    sum = 5'd9;
    sum_valid = 1'b1;
    @(negedge clk);
    sum = 5'd17;
    wait_done(low, g1);
    check("hold_t1", 32'(tens), 32'd0);
    check("hold_o1", 32'(ones), 32'd9);
    @(negedge clk);
    sum_valid = 1'b0;
    wait_done(low, g2);
    pulses = int'(g1) + int'(g2);
    check("hold_pulses", 32'(pulses), 32'd2);
    check("hold_t2", 32'(tens), 32'd1);
    check("hold_o2", 32'(ones), 32'd7);
    exp_t = 1;
    exp_o = 7;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (conv_done) pulses++;
    end
    check("hold_extra", 32'(pulses), 32'd0);

    // Reset during conversion of 22
    sum = 5'd22;
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_t = 0;
    exp_o = 0;
    check("abort_tens", 32'(tens), 32'd0);
    check("abort_ones", 32'(ones), 32'd0);
    check("abort_ready", 32'(sum_ready), 32'd1);
    check_disp("abort");
    pulses = int'(conv_done);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (conv_done) pulses++;
    end
    check("abort_pulse", 32'(pulses), 32'd0);

    // Every a+b from a 4-bit adder, random idle gaps
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        convert(a + b, "sweep");
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check_disp("gap");
        end
      end
    end

    // Random sums over the full 5-bit range
    for (int i = 0; i < 64; i++) begin
      v = int'($urandom_range(0, 31));
      convert(v, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
